sc_speed_tick_gen: RTL and testbench
====================================

// Module: sc_speed_tick_gen
// PURPOSE
//  Downstream consumer of the free-running speed counter (SC_upSPEEDCOUNTER). Compares counter value to a
//  level-dependent period, emits a one-cycle movement tick for lanes/cars, and drives the counter's
//  upcount_InLow (low = count, high = clear) to restart each period. Tracks game difficulty level
//  (level-up requests shorten the period) and supports pause.
// PARAMETERS
//  DATAWIDTH    27          width of counter value; must match counter instance
//  LEVELWIDTH   3           width of level; LEVEL_MAX = 2**LEVELWIDTH-1
//  BASE_PERIOD  50000000    tick period in clocks at level 0 (1 s @ 50 MHz)
//  STEP         5000000     period reduction per level
//  MIN_PERIOD   5000000     period floor; must be >=2 and < 2**DATAWIDTH
// PORTS
//  SC_SPEEDTICK_CLOCK_50      in   1           system clock, 50 MHz
//  SC_SPEEDTICK_RESET_InLow   in   1           asynchronous reset, active-low
//  SC_SPEEDTICK_count_InBUS   in   DATAWIDTH   counter value from SC_upSPEEDCOUNTER
//  SC_SPEEDTICK_levelUp_InLow in   1           level-up request, active-low, synchronous, any length
//  SC_SPEEDTICK_pause_InLow   in   1           pause while low
//  SC_SPEEDTICK_upcount_OutLow out 1           to counter upcount_InLow: 0 = count, 1 = clear
//  SC_SPEEDTICK_tick_Out      out  1           one-cycle movement pulse
//  SC_SPEEDTICK_level_OutBUS  out  LEVELWIDTH  current level
//  SC_SPEEDTICK_maxLevel_Out  out  1           high when level == LEVEL_MAX
// BEHAVIOUR
//  - All outputs registered. Reset: tick_Out=0, upcount_OutLow=1, level=0, maxLevel=0, state=ST_CLEAR,
//    levelUp history=1, threshold=PERIOD(0)-2. Reset is async on assert, takes effect mid-period.
//  - PERIOD(L) = max(BASE_PERIOD - L*STEP, MIN_PERIOD); computed without underflow (compare before subtract).
//    Threshold register = PERIOD(level)-2, reloaded the cycle after any level change.
//  - FSM states:
//    ST_CLEAR: upcount_OutLow=1 (counter clears). Next: pause_InLow==0 -> ST_PAUSE, else ST_RUN.
//    ST_RUN:   upcount_OutLow=0. pause_InLow==0 -> ST_PAUSE (no tick);
//              else count_InBUS >= threshold -> ST_CLEAR, tick_Out=1 for exactly that next cycle;
//              else stay.
//    ST_PAUSE: upcount_OutLow=1, tick_Out=0. pause_InLow==1 -> ST_CLEAR. Pause discards period phase.
//  - Timing: with counter attached, ticks are exactly PERIOD(level) clocks apart (P-1 counting values + CLEAR cycle).
//  - Level: falling edge of levelUp_InLow (history 1, now 0) increments level by 1; saturates at LEVEL_MAX;
//    held-low input counts once. maxLevel_Out = (level==LEVEL_MAX), updated same edge as level.
//  - Level change mid-period: new threshold applies on reload; the >= compare guarantees a tick within
//    3 cycles if count already exceeds new threshold (no wrap, no missed tick).
//  - Simultaneous: level-up and tick in same cycle -> both occur; pause and threshold hit -> pause wins.
//  - Counter value is never allowed to wrap: threshold < 2**DATAWIDTH-1 by parameter constraint.
// STRUCTURE
//  - Shared include (SC_SPEED_defs.vh): state encodings ST_CLEAR/ST_RUN/ST_PAUSE (2-bit) and a
//    period function used by this block and by the future HUD speed display.
//  - One sub-module: sc_speed_period_lut (combinational level -> threshold), instantiated once.
//  - Top: edge detector, level register, threshold register, FSM, output registers.
// TESTING (bench params: DATAWIDTH=8, LEVELWIDTH=3, BASE_PERIOD=10, STEP=2, MIN_PERIOD=4;
//          real SC_upSPEEDCOUNTER attached, its RESET_InHigh = ~RESET_InLow)
//  1 Reset low 3 cycles -> tick=0, upcount_OutLow=1, level=0, maxLevel=0; release, pause_InLow=1
//    -> consecutive tick pulses exactly 10 cycles apart, each 1 cycle wide.
//  2 levelUp pulses (1 cycle low) x3 -> periods 8, 6, 4; 4 more pulses -> level=7, maxLevel=1,
//    period stays 4; further pulse -> level stays 7.
//  3 levelUp held low 30 cycles -> level increments exactly once; at level 0 with count=7,
//    level-up -> tick within 3 cycles, then 8-cycle spacing.
//  4 pause_InLow low 20 cycles mid-period -> no ticks, upcount_OutLow=1 throughout; release
//    -> first tick 10 cycles after release edge, then 10-cycle spacing.
//  5 pause asserted in cycle count reaches threshold -> no tick; level-up in tick cycle -> tick and
//    level increment both occur.
//  6 Reset asserted async mid-period at level 3 -> outputs to reset values before next clock edge,
//    level=0; after release period = 10.

Source files
------------

// File: rtl/sc_speed_tick_gen_pkg.sv
// Shared definitions for the speed tick generator: FSM state encoding and the
// level-to-period function also intended for the HUD speed display.
package sc_speed_tick_gen_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } speed_state_t;

    // Period in clocks for a level; the floor test happens before the subtraction
    // so the result never underflows.
    function automatic int unsigned sc_speed_period(
        input int unsigned level,
        input int unsigned base_period,
        input int unsigned step,
        input int unsigned min_period
    );
        int unsigned cut;
        if (base_period <= min_period) begin
            return min_period;
        end
        cut = level * step;
        if (cut >= base_period - min_period) begin
            return min_period;
        end
        return base_period - cut;
    endfunction

endpackage

// File: rtl/sc_speed_tick_gen_if.sv
// Bundle between the speed tick generator and its environment (counter value,
// player controls in; counter control, tick and level status out).
interface sc_speed_tick_gen_if #(
    parameter int unsigned DATAWIDTH  = 27,
    parameter int unsigned LEVELWIDTH = 3
);
    logic [DATAWIDTH-1:0]  count;
    logic                  level_up_n;
    logic                  pause_n;
    logic                  upcount_n;
    logic                  tick;
    logic [LEVELWIDTH-1:0] level;
    logic                  max_level;

    modport master (
        output count, level_up_n, pause_n,
        input  upcount_n, tick, level, max_level
    );

    modport slave (
        input  count, level_up_n, pause_n,
        output upcount_n, tick, level, max_level
    );
endinterface

// File: rtl/sc_speed_tick_gen_period_lut.sv
// Combinational level -> compare threshold (period minus the two cycles spent
// in the clear state and on the registered compare).
module sc_speed_period_lut
    import sc_speed_tick_gen_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = 27,
    parameter int unsigned LEVELWIDTH  = 3,
    parameter int unsigned BASE_PERIOD = 50000000,
    parameter int unsigned STEP        = 5000000,
    parameter int unsigned MIN_PERIOD  = 5000000
) (
    input  logic [LEVELWIDTH-1:0] level,
    output logic [DATAWIDTH-1:0]  threshold
);
    always_comb begin
        threshold = DATAWIDTH'(sc_speed_period(32'(level), BASE_PERIOD, STEP, MIN_PERIOD) - 32'd2);
    end
endmodule

// File: rtl/sc_speed_tick_gen.sv
// Speed tick generator: watches the free-running counter, restarts it every
// level-dependent period, emits a one-cycle tick and tracks difficulty level.
module sc_speed_tick_gen
    import sc_speed_tick_gen_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = 27,
    parameter int unsigned LEVELWIDTH  = 3,
    parameter int unsigned BASE_PERIOD = 50000000,
    parameter int unsigned STEP        = 5000000,
    parameter int unsigned MIN_PERIOD  = 5000000
) (
    input  logic              SC_SPEEDTICK_CLOCK_50,
    input  logic              SC_SPEEDTICK_RESET_InLow,
    sc_speed_tick_gen_if.slave bus
);
    localparam logic [LEVELWIDTH-1:0] LEVEL_MAX  = '1;
    localparam logic [DATAWIDTH-1:0]  THRESH_RST =
        DATAWIDTH'(sc_speed_period(32'd0, BASE_PERIOD, STEP, MIN_PERIOD) - 32'd2);

    speed_state_t          state;
    logic                  level_hist;
    logic [LEVELWIDTH-1:0] level;
    logic [LEVELWIDTH-1:0] level_next;
    logic                  max_level;
    logic [DATAWIDTH-1:0]  threshold;
    logic [DATAWIDTH-1:0]  lut_threshold;
    logic                  tick;
    logic                  upcount_n;

    sc_speed_period_lut #(
        .DATAWIDTH  (DATAWIDTH),
        .LEVELWIDTH (LEVELWIDTH),
        .BASE_PERIOD(BASE_PERIOD),
        .STEP       (STEP),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_period_lut (
        .level    (level),
        .threshold(lut_threshold)
    );

    always_comb begin
        level_next = level + LEVELWIDTH'(1);
    end

    // Threshold follows the level register, so it reloads one cycle after a level change.
    always_ff @(posedge SC_SPEEDTICK_CLOCK_50 or negedge SC_SPEEDTICK_RESET_InLow) begin
        if (!SC_SPEEDTICK_RESET_InLow) begin
            level_hist <= 1'b1;
            level      <= '0;
            max_level  <= 1'b0;
            threshold  <= THRESH_RST;
        end else begin
            level_hist <= bus.level_up_n;
            threshold  <= lut_threshold;
            if (level_hist && !bus.level_up_n && level != LEVEL_MAX) begin
                level     <= level_next;
                max_level <= (level_next == LEVEL_MAX);
            end
        end
    end

    always_ff @(posedge SC_SPEEDTICK_CLOCK_50 or negedge SC_SPEEDTICK_RESET_InLow) begin
        if (!SC_SPEEDTICK_RESET_InLow) begin
            state     <= ST_CLEAR;
            upcount_n <= 1'b1;
            tick      <= 1'b0;
        end else begin
            tick <= 1'b0;
            unique case (state)
                ST_CLEAR: begin
                    if (!bus.pause_n) begin
                        state     <= ST_PAUSE;
                        upcount_n <= 1'b1;
                    end else begin
                        state     <= ST_RUN;
                        upcount_n <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Pause outranks a threshold hit in the same cycle.
                    if (!bus.pause_n) begin
                        state     <= ST_PAUSE;
                        upcount_n <= 1'b1;
                    end else if (bus.count >= threshold) begin
                        state     <= ST_CLEAR;
                        upcount_n <= 1'b1;
                        tick      <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    upcount_n <= 1'b1;
                    if (bus.pause_n) begin
                        state <= ST_CLEAR;
                    end
                end
                default: begin
                    state     <= ST_CLEAR;
                    upcount_n <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tick      = tick;
    assign bus.upcount_n = upcount_n;
    assign bus.level     = level;
    assign bus.max_level = max_level;
endmodule

// File: tb/tb_sc_speed_tick_gen.sv
// Directed self-checking bench for sc_speed_tick_gen with a behavioural
// up-counter attached (clear when upcount_n is high).
module tb_sc_speed_tick_gen;
    import sc_speed_tick_gen_pkg::*;

    logic clk;
    logic rst_n;
    logic counter_reset;
    int   checks;
    int   failures;

    sc_speed_tick_gen_if #(.DATAWIDTH(8), .LEVELWIDTH(3)) bus ();

    sc_speed_tick_gen #(
        .DATAWIDTH  (8),
        .LEVELWIDTH (3),
        .BASE_PERIOD(10),
        .STEP       (2),
        .MIN_PERIOD (4)
    ) dut (
        .SC_SPEEDTICK_CLOCK_50   (clk),
        .SC_SPEEDTICK_RESET_InLow(rst_n),
        .bus                     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign counter_reset = ~rst_n;

    always_ff @(posedge clk or posedge counter_reset) begin
        if (counter_reset) bus.count <= '0;
        else if (bus.upcount_n) bus.count <= '0;
        else bus.count <= bus.count + 8'd1;
    end

    // Returns the number of falling edges until tick is seen high, or -1 on timeout.
    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.tick === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic wait_count(input logic [7:0] value, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.count === value) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_level_up();
        bus.level_up_n = 1'b0;
        @(negedge clk);
        bus.level_up_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        bus.level_up_n = 1'b1;
        bus.pause_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
        checks++; if (bus.upcount_n !== 1'b1) begin failures++; $display("FAIL reset_upcount got=%b exp=1", bus.upcount_n); end
        checks++; if (bus.level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
        checks++; if (bus.max_level !== 1'b0) begin failures++; $display("FAIL reset_max got=%b exp=0", bus.max_level); end
        rst_n = 1'b1;
        // One clear cycle, then count values 0..8 compared: 10 clocks to the first tick.
        wait_tick(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL first_tick got=%0d exp=10", n); end
        for (int k = 0; k < 3; k++) begin
            wait_tick(n);
            checks++; if (n !== 10) begin failures++; $display("FAIL period_l0 got=%0d exp=10", n); end
        end
    endtask

    task automatic test_level_up();
        int n;
        int exp_period[7] = '{8, 6, 4, 4, 4, 4, 4};
        for (int i = 0; i < 7; i++) begin
            pulse_level_up();
            checks++; if (bus.level !== 3'(i + 1)) begin failures++; $display("FAIL level_up got=%0d exp=%0d", bus.level, i + 1); end
            checks++; if (bus.max_level !== (i == 6)) begin failures++; $display("FAIL max_level got=%b exp=%b", bus.max_level, (i == 6)); end
            wait_tick(n);
            wait_tick(n);
            checks++; if (n !== exp_period[i]) begin failures++; $display("FAIL level_period got=%0d exp=%0d", n, exp_period[i]); end
            @(negedge clk);
        end
        pulse_level_up();
        repeat (2) @(negedge clk);
        checks++; if (bus.level !== 3'd7) begin failures++; $display("FAIL level_saturate got=%0d exp=7", bus.level); end
        checks++; if (bus.max_level !== 1'b1) begin failures++; $display("FAIL max_saturate got=%b exp=1", bus.max_level); end
    endtask

    task automatic test_level_hold();
        int n;
        bit ok;
        do_reset();
        bus.level_up_n = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (bus.level !== 3'd1) begin failures++; $display("FAIL hold_level got=%0d exp=1", bus.level); end
        bus.level_up_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.level !== 3'd1) begin failures++; $display("FAIL hold_release got=%0d exp=1", bus.level); end

        do_reset();
        wait_count(8'd7, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL count7_timeout got=%b exp=1", ok); end
        bus.level_up_n = 1'b0;
        wait_tick(n);
        checks++; if (!(n >= 1 && n <= 3)) begin failures++; $display("FAIL late_level_tick got=%0d exp=1..3", n); end
        bus.level_up_n = 1'b1;
        wait_tick(n);
        checks++; if (n !== 8) begin failures++; $display("FAIL late_level_period got=%0d exp=8", n); end
        checks++; if (bus.level !== 3'd1) begin failures++; $display("FAIL late_level got=%0d exp=1", bus.level); end
    endtask

    task automatic test_pause();
        int n;
        do_reset();
        wait_tick(n);
        repeat (4) @(negedge clk);
        bus.pause_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL pause_tick cyc=%0d got=%b exp=0", i, bus.tick); end
            checks++; if (bus.upcount_n !== 1'b1) begin failures++; $display("FAIL pause_upcount cyc=%0d got=%b exp=1", i, bus.upcount_n); end
        end
        bus.pause_n = 1'b1;
        // Tick lands 10 clocks after the first edge that samples the release (11 falling edges from here).
        wait_tick(n);
        checks++; if (n !== 11) begin failures++; $display("FAIL pause_resume got=%0d exp=11", n); end
        wait_tick(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL pause_period got=%0d exp=10", n); end
    endtask

    task automatic test_simultaneous();
        int n;
        bit ok;
        wait_count(8'd8, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL count8_timeout got=%b exp=1", ok); end
        bus.pause_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL pause_wins cyc=%0d got=%b exp=0", i, bus.tick); end
        end
        bus.pause_n = 1'b1;
        wait_tick(n);
        checks++; if (n !== 11) begin failures++; $display("FAIL pause_wins_resume got=%0d exp=11", n); end

        wait_count(8'd8, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL count8b_timeout got=%b exp=1", ok); end
        bus.level_up_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.tick !== 1'b1) begin failures++; $display("FAIL both_tick got=%b exp=1", bus.tick); end
        checks++; if (bus.level !== 3'd1) begin failures++; $display("FAIL both_level got=%0d exp=1", bus.level); end
        bus.level_up_n = 1'b1;
        wait_tick(n);
        checks++; if (n !== 8) begin failures++; $display("FAIL both_period got=%0d exp=8", n); end
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse_level_up();
            @(negedge clk);
        end
        checks++; if (bus.level !== 3'd3) begin failures++; $display("FAIL pre_reset_level got=%0d exp=3", bus.level); end
        wait_tick(n);
        @(negedge clk);
        @(posedge clk);
        #2;
        checks++; if (bus.upcount_n !== 1'b0) begin failures++; $display("FAIL pre_reset_run got=%b exp=0", bus.upcount_n); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.tick !== 1'b0) begin failures++; $display("FAIL async_tick got=%b exp=0", bus.tick); end
        checks++; if (bus.upcount_n !== 1'b1) begin failures++; $display("FAIL async_upcount got=%b exp=1", bus.upcount_n); end
        checks++; if (bus.level !== 3'd0) begin failures++; $display("FAIL async_level got=%0d exp=0", bus.level); end
        checks++; if (bus.max_level !== 1'b0) begin failures++; $display("FAIL async_max got=%b exp=0", bus.max_level); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL after_reset_first got=%0d exp=10", n); end
        wait_tick(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL after_reset_period got=%0d exp=10", n); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_level_up();
        test_level_hold();
        test_pause();
        test_simultaneous();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
